// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field/word handshake bundle for the RV32I instruction encoder
interface instr_encoder_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
);
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [4:0]                 opcode_i;
    logic [4:0]                 rd_addr_i;
    logic [4:0]                 rs1_addr_i;
    logic [4:0]                 rs2_addr_i;
    logic [31:0]                imm_i;
    logic [3:0]                 alu_op_i;
    logic                       addr_clr_i;
    logic                       instr_valid_o;
    logic                       instr_ready_i;
    logic [31:0]                instr_o;
    logic [ADDR_W-1:0]          instr_addr_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       err_o;

    modport slave (
        input  in_valid_i, opcode_i, rd_addr_i, rs1_addr_i, rs2_addr_i, imm_i, alu_op_i,
        input  addr_clr_i, instr_ready_i,
        output in_ready_o, instr_valid_o, instr_o, instr_addr_o, count_o, err_o
    );

    modport master (
        output in_valid_i, opcode_i, rd_addr_i, rs1_addr_i, rs2_addr_i, imm_i, alu_op_i,
        output addr_clr_i, instr_ready_i,
        input  in_ready_o, instr_valid_o, instr_o, instr_addr_o, count_o, err_o
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field encoder with output FIFO and program address counter (optional ENC_CHECK_EN)
module instr_encoder #(
    parameter int                n         = 32,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    instr_encoder_if.slave  bus
);
    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam int                 CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    localparam logic [4:0] OP_LOAD   = 5'd0;
    localparam logic [4:0] OP_IALU   = 5'd4;
    localparam logic [4:0] OP_AUIPC  = 5'd5;
    localparam logic [4:0] OP_STORE  = 5'd8;
    localparam logic [4:0] OP_R      = 5'd12;
    localparam logic [4:0] OP_LUI    = 5'd13;
    localparam logic [4:0] OP_BRANCH = 5'd24;
    localparam logic [4:0] OP_JALR   = 5'd25;
    localparam logic [4:0] OP_JAL    = 5'd27;

    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;

    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        b30;

    assign imm = bus.imm_i;
    assign rd  = bus.rd_addr_i;
    assign rs1 = bus.rs1_addr_i;
    assign rs2 = bus.rs2_addr_i;
    assign f3  = bus.alu_op_i[2:0];
    assign b30 = bus.alu_op_i[3];

    always_comb begin
        enc_word = 32'h0000_0013;
        case (bus.opcode_i)
            OP_R:      enc_word = {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            OP_IALU: begin
                // Shift-immediates carry the arithmetic/logical select in bit 30
                if (f3 == 3'b001 || f3 == 3'b101)
                    enc_word = {1'b0, b30, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011};
                else
                    enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
            end
            OP_LOAD:   enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
            OP_JALR:   enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            OP_STORE:  enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            OP_BRANCH: enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            OP_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            OP_LUI:    enc_word = {imm[31:12], rd, 7'b0110111};
            OP_AUIPC:  enc_word = {imm[31:12], rd, 7'b0010111};
            default:   enc_word = 32'h0000_0013;
        endcase
    end

    assign bus.in_ready_o    = (count < FULL_CNT);
    assign bus.instr_valid_o = (count != '0);
    assign accept            = bus.in_valid_i & bus.in_ready_o;
    assign pop               = bus.instr_valid_o & bus.instr_ready_i;

`ifdef ENC_CHECK_EN
    logic enc_bad;
    logic fits12;
    logic fits13;
    logic fits21;
    logic err;

    // A value fits a k-bit signed field when all bits from k-1 upward agree
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_bad = 1'b0;
        case (bus.opcode_i)
            OP_R:                        enc_bad = 1'b0;
            OP_IALU, OP_LOAD, OP_JALR,
            OP_STORE:                    enc_bad = ~fits12;
            OP_BRANCH:                   enc_bad = ~fits13 | imm[0];
            OP_JAL:                      enc_bad = ~fits21 | imm[0];
            OP_LUI, OP_AUIPC:            enc_bad = |imm[11:0];
            default:                     enc_bad = 1'b1;
        endcase
    end

    assign push = accept & ~enc_bad;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.addr_clr_i)
            err <= 1'b0;
        else if (accept && enc_bad)
            err <= 1'b1;
    end

    assign bus.err_o = err;
`else
    assign push      = accept;
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Clear takes priority over the pop increment; the popped word already saw the old address
    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.addr_clr_i)
            addr <= BASE_ADDR;
        else if (pop)
            addr <= addr + ADDR_W'(4);
    end

    assign bus.instr_o      = bus.instr_valid_o ? mem[rd_ptr] : 32'h0;
    assign bus.instr_addr_o = addr;
    assign bus.count_o      = count;
endmodule
